// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue controller: op bit positions and FSM encoding.
package mul_pkg;

  localparam int unsigned MUL_W   = 0;
  localparam int unsigned MULH_W  = 1;
  localparam int unsigned MULH_WU = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } mul_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return op[MUL_W] | op[MULH_W] | op[MULH_WU];
  endfunction

endpackage

// File: rtl/mul_watchdog.sv
// Counts consecutive cycles an operation is outstanding and flags a missing completion.
module mul_watchdog #(
  parameter int unsigned Cycles = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic done,
  output logic timeout
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

  logic [CntW-1:0] cnt_q;

  // Fires in the Cycles-th outstanding cycle; a same-cycle done wins.
  assign timeout = active & ~done & (cnt_q == CntW'(Cycles - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (active && !timeout && !done) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issues multiply ops from EXE to an external multiplier and holds the result for MEM.
// Optional watchdog enabled by defining MUL_TIMEOUT_EN.
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned MUL_TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_valid,
  input  logic [9:0]  es_mul_div_op,
  input  logic [31:0] es_src1,
  input  logic [31:0] es_src2,
  input  logic        ms_allowin,
  input  logic        flush,
  output logic        mult,
  output logic [9:0]  mul_div_op,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] mul_result,
  input  logic        done,
  output logic        es_stall,
  output logic [31:0] md_result,
  output logic        md_result_valid,
  output logic        md_error
);

  mul_state_e state_q;
  logic       es_is_mul;
  logic       launch;
  logic       timeout;

  assign es_is_mul = es_valid & is_mul_op(es_mul_div_op[2:0]);
  assign launch    = (state_q == StIdle) & es_is_mul & ~flush;

`ifdef MUL_TIMEOUT_EN
  mul_watchdog #(
    .Cycles (MUL_TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .active  ((state_q == StBusy) || (state_q == StDrain)),
    .done    (done),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_error <= 1'b0;
    end else if (timeout) begin
      md_error <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^MUL_TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign md_error           = 1'b0;
`endif

  // Stall is combinational so EXE holds in the launch cycle; forced low while in reset.
  assign es_stall = ~reset & (launch
                            | (state_q == StBusy)
                            | ((state_q == StHold) & ~ms_allowin)
                            | ((state_q == StDrain) & es_is_mul));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      mult            <= 1'b0;
      md_result_valid <= 1'b0;
      md_result       <= '0;
      mul_div_op      <= '0;
      alu_src1        <= '0;
      alu_src2        <= '0;
    end else begin
      mult <= 1'b0;
      case (state_q)
        StIdle: begin
          if (launch) begin
            mult       <= 1'b1;
            mul_div_op <= es_mul_div_op;
            alu_src1   <= es_src1;
            alu_src2   <= es_src2;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          if (done) begin
            if (flush) begin
              state_q <= StIdle;
            end else begin
              md_result       <= mul_result;
              md_result_valid <= 1'b1;
              state_q         <= StHold;
            end
          end else if (timeout) begin
            state_q <= StIdle;
          end else if (flush) begin
            state_q <= StDrain;
          end
        end
        StHold: begin
          if (flush || ms_allowin) begin
            md_result_valid <= 1'b0;
            state_q         <= StIdle;
          end
        end
        StDrain: begin
          // Result of a flushed op is dropped; just wait for the multiplier to go idle.
          if (done || timeout) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural multiplier and EXE/MEM environment.
module tb_mul_issue_ctrl;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        es_valid = 1'b0;
  logic [9:0]  es_mul_div_op = '0;
  logic [31:0] es_src1 = '0;
  logic [31:0] es_src2 = '0;
  logic        ms_allowin = 1'b1;
  logic        flush = 1'b0;
  logic        mult;
  logic [9:0]  mul_div_op;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] mul_result = '0;
  logic        done = 1'b0;
  logic        es_stall;
  logic [31:0] md_result;
  logic        md_result_valid;
  logic        md_error;

  mul_issue_ctrl #(
    .MUL_TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .es_valid        (es_valid),
    .es_mul_div_op   (es_mul_div_op),
    .es_src1         (es_src1),
    .es_src2         (es_src2),
    .ms_allowin      (ms_allowin),
    .flush           (flush),
    .mult            (mult),
    .mul_div_op      (mul_div_op),
    .alu_src1        (alu_src1),
    .alu_src2        (alu_src2),
    .mul_result      (mul_result),
    .done            (done),
    .es_stall        (es_stall),
    .md_result       (md_result),
    .md_result_valid (md_result_valid),
    .md_error        (md_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [9:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } launch_t;

  launch_t     launch_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mul_ref(input logic [9:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    pu = {32'd0, a} * {32'd0, b};
    if (op[MUL_W]) return ps[31:0];
    if (op[MULH_W]) return ps[63:32];
    return pu[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Environment state: what the multiplier is doing and whether its result is still wanted.
  bit          in_flight = 0;
  bit          op_alive = 0;
  bit          rand_allow = 1;
  int          done_due = -1;
  int          mult_cyc = -1;
  int          cur_lat = 4;
  int          hold_left = 0;
  logic [31:0] cur_exp = '0;

  // Called at posedge+1 to set this cycle's environment inputs.
  task automatic cyc_begin(input int flush_off);
    done       = 1'b0;
    flush      = 1'b0;
    mul_result = $urandom;
    if (mult) begin
      check("single_issue", in_flight, 0);
      in_flight = 1;
      op_alive  = 1;
      mult_cyc  = cyc;
      done_due  = cyc + cur_lat;
    end
    if (flush_off >= 0 && mult_cyc >= 0 && cyc == mult_cyc + flush_off) flush = 1'b1;
    if (in_flight && cyc == done_due) begin
      done       = 1'b1;
      mul_result = mul_ref(mul_div_op, alu_src1, alu_src2);
      in_flight  = 0;
      if (op_alive && !flush) exp_q.push_back(cur_exp);
    end else if (!in_flight && $urandom_range(0, 3) == 0) begin
      done = 1'b1;
    end
    if (flush) op_alive = 0;
    if (md_result_valid && hold_left > 0) begin
      ms_allowin = 1'b0;
      hold_left--;
    end else if (rand_allow) begin
      ms_allowin = ($urandom_range(0, 2) != 0);
    end else begin
      ms_allowin = 1'b1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int hold_low);
    launch_t e;
    es_valid      = 1'b1;
    es_mul_div_op = op;
    es_src1       = a;
    es_src2       = b;
    e.op = op;
    e.a  = a;
    e.b  = b;
    launch_q.push_back(e);
    cur_exp    = mul_ref(op, a, b);
    cur_lat    = lat;
    mult_cyc   = -1;
    hold_left  = hold_low;
    rand_allow = (hold_low < 0);
  endtask

  task automatic run_mul(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int flush_off, input int hold_low);
    bit gone = 0;
    present(op, a, b, lat, hold_low);
    for (int k = 0; k < 100 && !gone; k++) begin
      cyc_begin(flush_off);
      @(negedge clk);
      if (flush || !es_stall) gone = 1;
      next_cycle();
    end
    es_valid = 1'b0;
    if (!gone) check("accept_bound", 0, 1);
  endtask

  task automatic run_other(input logic [9:0] op);
    es_valid      = 1'b1;
    es_mul_div_op = op;
    es_src1       = $urandom;
    es_src2       = $urandom;
    cyc_begin(-1);
    @(negedge clk);
    check("nonmul_stall", es_stall, 0);
    next_cycle();
    es_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin(-1);
      @(negedge clk);
      next_cycle();
    end
  endtask

  task automatic reset_mid_busy();
    present(10'b1 << MUL_W, $urandom, $urandom, 10, 0);
    for (int k = 0; k < 20 && !(mult_cyc >= 0 && cyc >= mult_cyc + 2); k++) begin
      cyc_begin(-1);
      @(negedge clk);
      next_cycle();
    end
    check("pre_reset_busy", es_stall, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mult", mult, 0);
    check("rst_es_stall", es_stall, 0);
    check("rst_valid", md_result_valid, 0);
    check("rst_error", md_error, 0);
    check("rst_md_result", md_result, 0);
    check("rst_op", mul_div_op, 0);
    check("rst_src1", alu_src1, 0);
    check("rst_src2", alu_src2, 0);
    in_flight = 0;
    op_alive  = 0;
    es_valid  = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    next_cycle();
    cyc_begin(-1);
    done       = 1'b1;
    mul_result = 32'hDEAD_BEEF;
    next_cycle();
    @(negedge clk);
    check("late_done_valid", md_result_valid, 0);
    check("late_done_stall", es_stall, 0);
    next_cycle();
  endtask

`ifdef MUL_TIMEOUT_EN
  task automatic timeout_test();
    int c_err = -1;
    present(10'b1 << MUL_W, 32'd7, 32'd9, 1000, 0);
    for (int k = 0; k < 20 && mult_cyc < 0; k++) begin
      cyc_begin(-1);
      @(negedge clk);
      next_cycle();
    end
    es_valid = 1'b0;
    for (int k = 0; k < 40 && c_err < 0; k++) begin
      if (md_error) begin
        c_err = cyc;
      end else begin
        cyc_begin(-1);
        @(negedge clk);
        next_cycle();
      end
    end
    check("timeout_latency", c_err - mult_cyc, 8);
    for (int k = 0; k < 3; k++) begin
      cyc_begin(-1);
      @(negedge clk);
      check("timeout_sticky", md_error, 1);
      check("timeout_idle_stall", es_stall, 0);
      next_cycle();
    end
    #2 reset = 1'b1;
    #1;
    check("timeout_cleared", md_error, 0);
    in_flight = 0;
    op_alive  = 0;
    @(negedge clk);
    #1 reset = 1'b0;
    next_cycle();
  endtask
`endif

  // Monitor: pops expectations whenever the DUT launches or presents a result.
  bit          prev_valid = 0;
  logic [31:0] held = '0;
  launch_t     mon_e;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 0;
    end else begin
      if (mult) begin
        if (launch_q.size() == 0) begin
          check("mult_unexpected", 1, 0);
        end else begin
          mon_e = launch_q.pop_front();
          check("launch_op", mul_div_op, mon_e.op);
          check("launch_src1", alu_src1, mon_e.a);
          check("launch_src2", alu_src2, mon_e.b);
        end
      end
      if (md_result_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            check("result_unexpected", 1, 0);
          end else begin
            held = exp_q.pop_front();
            check("md_result", md_result, held);
          end
        end else begin
          check("md_result_hold", md_result, held);
        end
        check("hold_stall", es_stall, !ms_allowin);
      end
      prev_valid = md_result_valid;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_mult", mult, 0);
    check("reset_stall", es_stall, 0);
    check("reset_valid", md_result_valid, 0);
    check("reset_error", md_error, 0);
    check("reset_result", md_result, 0);
    check("reset_src1", alu_src1, 0);
    reset = 1'b0;
    next_cycle();

    run_mul(10'b1 << MUL_W, 32'd3, 32'd5, 4, -1, 2);
    idle(2);
    run_mul(10'b1 << MULH_WU, 32'hFFFF_FFFF, 32'd2, 3, -1, 3);
    idle(2);
    run_mul(10'b1 << MUL_W, 32'd11, 32'd13, 5, 2, 0);
    run_mul(10'b1 << MULH_W, 32'h8000_0000, 32'h7FFF_FFFF, 3, -1, 0);
    idle(2);
    run_mul(10'b1 << MUL_W, 32'd100, 32'd200, 3, 3, 0);
    idle(8);
    reset_mid_busy();
    idle(2);

    for (int t = 0; t < 150; t++) begin
      logic [9:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      int          fo;
      int          idx;
      op = {7'($urandom), 3'b000};
      if ($urandom_range(0, 9) < 7) begin
        idx     = $urandom_range(0, 2);
        op[idx] = 1'b1;
        a       = pick();
        b       = pick();
        lat     = $urandom_range(1, 6);
        fo      = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat + 2) : -1;
        run_mul(op, a, b, lat, fo, -1);
      end else begin
        run_other(op);
      end
      idle($urandom_range(0, 2));
    end

    idle(20);
    check("results_drained", exp_q.size(), 0);
    check("launches_drained", launch_q.size(), 0);
`ifdef MUL_TIMEOUT_EN
    timeout_test();
`else
    check("error_tied_low", md_error, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "simulation did not finish");
  end

endmodule
